// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage combinational ALU plus multi-cycle multiply/divide unit with HI/LO
module alu_mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [3:0]               opt,
  output logic [WIDTH-1:0]         res,
  output logic                     overf,
  input  logic [2:0]               md_op,
  input  logic                     md_start,
  output logic                     busy,
  output logic [WIDTH-1:0]         hi,
  output logic [WIDTH-1:0]         lo
);
  localparam int SW   = $clog2(WIDTH);
  localparam int LUI  = (WIDTH >= 32) ? 16 : WIDTH / 2;
  localparam int CMAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CW   = $clog2(CMAX);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t                 r_state, w_next;
  logic [CW-1:0]          r_cnt;
  logic [2*WIDTH-1:0]     r_ma, r_mb, w_prod;
  logic [WIDTH-1:0]       r_quo, r_rem, r_dvs, w_qn, w_rn, w_abs_a, w_abs_b;
  logic                   r_nq, r_nr, r_dz;
  logic [WIDTH:0]         w_sum, w_dif, w_sh, w_trial;
  logic                   w_acc, w_last, w_sa, w_sb, w_sgn_m;

  assign w_sum   = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign w_dif   = {a[WIDTH-1], a} - {b[WIDTH-1], b};
  assign busy    = r_state != S_IDLE;
  assign w_acc   = md_start && !busy && md_op != 3'd0 && md_op != 3'd7;
  assign w_last  = r_cnt == '0;
  assign w_sa    = md_op == 3'd3 && a[WIDTH-1];
  assign w_sb    = md_op == 3'd3 && b[WIDTH-1];
  assign w_abs_a = w_sa ? -a : a;
  assign w_abs_b = w_sb ? -b : b;
  assign w_sgn_m = md_op == 3'd1;
  assign w_prod  = r_ma * r_mb;
  assign w_sh    = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_sh - {1'b0, r_dvs};
  assign w_qn    = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_rn    = w_trial[WIDTH] ? w_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];

  // ALU result and signed-overflow flag
  always_comb begin
    res   = '0;
    overf = 1'b0;
    case (opt)
      4'd0:  begin res = w_sum[WIDTH-1:0]; overf = w_sum[WIDTH] ^ w_sum[WIDTH-1]; end
      4'd1:  begin res = w_dif[WIDTH-1:0]; overf = w_dif[WIDTH] ^ w_dif[WIDTH-1]; end
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd4:  res = a ^ b;
      4'd5:  res = ~(a | b);
      4'd6:  res = b << LUI;
      4'd7:  res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'd8:  res = {{(WIDTH-1){1'b0}}, a < b};
      4'd9:  res = b << shamt;
      4'd10: res = b >> shamt;
      4'd11: res = $signed(b) >>> shamt;
      4'd12: res = b << a[SW-1:0];
      4'd13: res = b >> a[SW-1:0];
      4'd14: res = $signed(b) >>> a[SW-1:0];
      default: res = '1;
    endcase
  end

  // MDU state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // MDU next state: idle until a mult/div is accepted, back to idle on the last busy cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = !w_acc ? S_IDLE :
                        (md_op == 3'd1 || md_op == 3'd2) ? S_MUL :
                        (md_op == 3'd3 || md_op == 3'd4) ? S_DIV : S_IDLE;
      default: w_next = w_last ? S_IDLE : r_state;
    endcase
  end

  // MDU datapath: operand capture, restoring divide iteration, atomic HI/LO commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ma  <= '0;
      r_mb  <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_nq  <= 1'b0;
      r_nr  <= 1'b0;
      r_dz  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else if (w_acc) begin
      if (md_op == 3'd5) hi <= a;
      else if (md_op == 3'd6) lo <= a;
      else if (md_op == 3'd1 || md_op == 3'd2) begin
        r_ma  <= {{WIDTH{w_sgn_m & a[WIDTH-1]}}, a};
        r_mb  <= {{WIDTH{w_sgn_m & b[WIDTH-1]}}, b};
        r_cnt <= CW'(MUL_CYCLES - 1);
      end else begin
        r_quo <= w_abs_a;
        r_dvs <= w_abs_b;
        r_rem <= '0;
        r_nq  <= w_sa ^ w_sb;
        r_nr  <= w_sa;
        r_dz  <= b == '0;
        r_cnt <= CW'(WIDTH - 1);
      end
    end else if (busy) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_state == S_DIV) begin
        r_quo <= w_qn;
        r_rem <= w_rn;
      end
      if (w_last && r_state == S_MUL) {hi, lo} <= w_prod;
      else if (w_last && !r_dz) begin
        lo <= r_nq ? -w_qn : w_qn;
        hi <= r_nr ? -w_rn : w_rn;
      end
    end
  end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised execute-stage unit for the pipelined CPU.
- Single-cycle combinational ALU: generalised width, extended op set, signed-overflow flag.
- Multi-cycle multiply/divide unit (MDU) with architectural HI/LO registers and a busy handshake.
- The stall unit reads `busy` to hold dependent mult/div/mfhi/mflo instructions in the decode stage.

Parameters:
- WIDTH, 32, datapath width in bits (≥ 8).
- MUL_CYCLES, 5, multiply latency in cycles (≥ 1).
- Divide latency is fixed at WIDTH cycles (radix-2 iterative).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt, or the already-extended immediate).
- shamt  in  $clog2(WIDTH)  shift amount for the constant-shift ops.
- opt  in  4  ALU operation select.
- res  out  WIDTH  ALU result (combinational).
- overf  out  1  signed overflow flag (combinational).
- md_op  in  3  MDU operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
- md_start  in  1  one-cycle request qualifying md_op.
- busy  out  1  MDU operation in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- ALU path is purely combinational; it has no dependency on clk, rst_n or MDU state.
- opt encodings:
  - 0: a+b. overf is set when the sign-extended (WIDTH+1)-bit sum has its two top bits differing.
  - 1: a−b. overf uses the same rule as add.
  - 2: a&b.
  - 3: a|b.
  - 4: a^b.
  - 5: ~(a|b).
  - 6: b<<16. For WIDTH<32, this is b<<(WIDTH/2).
  - 7: slt, signed; result is 1 or 0.
  - 8: sltu, unsigned; result is 1 or 0.
  - 9: b<<shamt.
  - 10: b>>shamt, logical.
  - 11: b>>>shamt, arithmetic.
  - 12: b<<a[log2W-1:0].
  - 13: b>>a[log2W-1:0].
  - 14: b>>>a[log2W-1:0].
  - 15: res is all-ones.
  - overf is 0 for every opt other than 0 and 1.
- Reset: hi=0, lo=0, busy=0, internal counter and iteration registers cleared. Reset takes effect immediately (asynchronous), including mid-operation; the in-flight result is discarded.
- Request acceptance:
  - A request is accepted on a rising edge where md_start=1, busy=0 and md_op is in 1..6.
  - md_start while busy=1 is ignored, with no queueing.
  - md_op=0 or md_op=7 with md_start=1 is a no-op.
- mthi / mtlo: hi (or lo) ← a at the accepting edge. busy stays 0.
- mult / multu:
  - Operands are captured at the accepting edge.
  - busy=1 from that edge for exactly MUL_CYCLES cycles.
  - At the edge where busy returns to 0, {hi,lo} ← the 2·WIDTH-bit product (signed for mult, unsigned for multu).
- div / divu:
  - Restoring radix-2 divider, one quotient bit per cycle.
  - busy=1 for exactly WIDTH cycles.
  - At the final edge: lo ← quotient, hi ← remainder.
- Signed divide rules:
  - Operate on magnitudes.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN_INT / −1: lo=MIN_INT, hi=0. No trap.
- Divide by zero (b=0 at capture): busy still runs WIDTH cycles; hi and lo are left unchanged.
- hi/lo are never partially updated; both change on the same edge that busy falls.
- While busy=1, hi/lo hold their pre-operation values. A same-edge busy-fall and new md_start is the boundary case: the new request is ignored because busy=1 at that edge. A new request is accepted on the following edge.
- Operand or opt changes after capture do not affect an in-flight MDU operation.

Test Plan:
- Add overflow: opt=0, a=0x7FFFFFFF, b=1 → res=0x80000000, overf=1. Same operands with opt=1 → res=0x7FFFFFFE, overf=0.
- Signed multiply: md_op=1, md_start=1, a=0xFFFFFFFD (−3), b=5 → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1. Repeat with multu → hi=0x00000004, lo=0xFFFFFFF1.
- Signed divide: md_op=3, a=0xFFFFFFF9 (−7), b=2 → busy 32 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: mthi a=0x11, mtlo a=0x22, then div with b=0 → busy 32 cycles, hi=0x11 and lo=0x22 unchanged.
- Busy rejection: start mult; pulse md_start with mtlo a=0xDEAD at cycle 2 → ignored, lo ends equal to the product low word. mtlo issued one cycle after busy falls → lo=0xDEAD.
- Reset mid-divide: deassert rst_n at cycle 10 of a divu → busy, hi and lo become 0 immediately. After release, a new divu 100/7 → lo=14, hi=2 after 32 cycles.
